// File: rtl/measure_hex_display.sv
// Sequential double-dabble conversion of a 14-bit measurement to five BCD digits driving
// five active-low 7-segment displays. Optional macro: LEADING_ZERO_BLANK_EN.
module measure_hex_display #(
    parameter int unsigned REFRESH_DIV = 2_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [13:0] num,
    input  logic        update,
    output logic        busy,
    output logic [19:0] bcd,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4
);

    localparam int unsigned DW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t         state, state_next;
    logic [DW-1:0]  div;
    logic           tick;
    logic           pending;
    logic [13:0]    last_num;
    logic [33:0]    shreg;
    logic [33:0]    adj;
    logic [3:0]     cnt;
    logic           done_d;
    logic           start;
    logic [6:0]     seg [5];

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign tick = (div == DW'(REFRESH_DIV - 1));
    assign busy = (state != IDLE);

    // A same-cycle update counts as pending so it starts immediately from IDLE.
    assign start = pending | update | (tick & (num != last_num));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt == 4'd13) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        adj = shreg;
        for (int unsigned i = 0; i < 5; i++) begin
            if (shreg[14 + 4*i +: 4] >= 4'd5)
                adj[14 + 4*i +: 4] = shreg[14 + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 5; i++)
            seg[i] = seg7(bcd[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        // Blank from the most significant digit down while zeros continue; HEX0 never blanks.
        begin
            logic lead;
            lead = 1'b1;
            for (int unsigned i = 4; i >= 1; i--) begin
                if (lead && (bcd[4*i +: 4] == 4'd0))
                    seg[i] = 7'h7F;
                else
                    lead = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            div      <= '0;
            pending  <= 1'b0;
            last_num <= '0;
            shreg    <= '0;
            cnt      <= '0;
            bcd      <= '0;
            done_d   <= 1'b0;
            HEX0     <= '1;
            HEX1     <= '1;
            HEX2     <= '1;
            HEX3     <= '1;
            HEX4     <= '1;
        end else begin
            state  <= state_next;
            div    <= tick ? '0 : div + 1'b1;
            done_d <= (state == DONE);

            if (state == IDLE && start)
                pending <= 1'b0;
            else if (update)
                pending <= 1'b1;

            case (state)
                LOAD: begin
                    shreg    <= {20'd0, num};
                    last_num <= num;
                    cnt      <= '0;
                end
                SHIFT: begin
                    shreg <= adj << 1;
                    cnt   <= cnt + 4'd1;
                end
                DONE:    bcd <= shreg[33:14];
                default: ;
            endcase

            if (done_d) begin
                HEX0 <= seg[0];
                HEX1 <= seg[1];
                HEX2 <= seg[2];
                HEX3 <= seg[3];
                HEX4 <= seg[4];
            end
        end
    end

endmodule

// File: tb/tb_measure_hex_display.sv
// Directed self-checking bench for measure_hex_display with a short refresh period.
// Honours LEADING_ZERO_BLANK_EN for the expected display values.
module tb_measure_hex_display;

    localparam int unsigned DIV = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] num = '0;
    logic        update = 1'b0;
    logic        busy;
    logic [19:0] bcd;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;

    int checks = 0;
    int errors = 0;
    int n;

    measure_hex_display #(.REFRESH_DIV(DIV)) dut (
        .clock  (clock),
        .reset  (reset),
        .num    (num),
        .update (update),
        .busy   (busy),
        .bcd    (bcd),
        .HEX0   (HEX0),
        .HEX1   (HEX1),
        .HEX2   (HEX2),
        .HEX3   (HEX3),
        .HEX4   (HEX4)
    );

    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e4, input logic [6:0] e3,
                           input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, "_hex4"}, 20'(HEX4), 20'(e4));
        chk({tag, "_hex3"}, 20'(HEX3), 20'(e3));
        chk({tag, "_hex2"}, 20'(HEX2), 20'(e2));
        chk({tag, "_hex1"}, 20'(HEX1), 20'(e1));
        chk({tag, "_hex0"}, 20'(HEX0), 20'(e0));
    endtask

    // Called on a negedge while idle; returns on the negedge of the LOAD cycle.
    task automatic pulse(input logic [13:0] v);
        num    = v;
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
    endtask

    // Counts busy cycles until the first idle negedge, bounded.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    task automatic count_busy(input int unsigned len, output int highs);
        highs = 0;
        for (int unsigned i = 0; i < len; i++) begin
            @(negedge clock);
            if (busy) highs++;
        end
    endtask

    initial begin
        // 1: reset state and no conversion while num equals last_num
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", 20'(busy), 20'd0);
        chk("rst_bcd", bcd, 20'h00000);
        chk_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        count_busy(3 * DIV, n);
        chk("idle_no_conv", 20'(n), 20'd0);
        chk_hex("idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // 2: forced conversion of 1234
        pulse(14'd1234);
        wait_idle(n);
        chk("c1234_busy_len", 20'(n), 20'd16);
        chk("c1234_bcd", bcd, 20'h01234);
        @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        chk_hex("c1234", 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19);
`else
        chk_hex("c1234", 7'h40, 7'h79, 7'h24, 7'h30, 7'h19);
`endif

        // 3: tick-triggered conversion of the maximum value
        num = 14'd16383;
        n = 0;
        while (!busy && n < int'(DIV) + 4) begin
            @(negedge clock);
            n++;
        end
        chk("tick_start", 20'(busy), 20'd1);
        wait_idle(n);
        chk("c16383_bcd", bcd, 20'h16383);
        @(negedge clock);
        chk_hex("c16383", 7'h79, 7'h02, 7'h30, 7'h00, 7'h30);
        count_busy(DIV + 4, n);
        chk("tick_same_num", 20'(n), 20'd0);

        // 4: update and num change mid-conversion
        pulse(14'd100);
        repeat (5) @(negedge clock);
        num    = 14'd9999;
        update = 1'b1;
        @(negedge clock);
        update = 1'b0;
        wait_idle(n);
        chk("b2b_first_bcd", bcd, 20'h00100);
        chk("b2b_gap_idle", 20'(busy), 20'd0);
        @(negedge clock);
        chk("b2b_restart", 20'(busy), 20'd1);
        wait_idle(n);
        chk("b2b_second_len", 20'(n), 20'd16);
        chk("b2b_second_bcd", bcd, 20'h09999);
        @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        chk_hex("c9999", 7'h7F, 7'h10, 7'h10, 7'h10, 7'h10);
`else
        chk_hex("c9999", 7'h40, 7'h10, 7'h10, 7'h10, 7'h10);
`endif

        // 5: reset during SHIFT aborts without writing bcd
        pulse(14'd5000);
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", 20'(busy), 20'd0);
        chk("abort_bcd", bcd, 20'h00000);
        chk_hex("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        reset = 1'b0;
        num   = 14'd0;
        count_busy(3 * DIV, n);
        chk("abort_no_conv", 20'(n), 20'd0);
        chk("abort_bcd_hold", bcd, 20'h00000);

        // 6: single-digit and zero display
        pulse(14'd7);
        wait_idle(n);
        chk("c7_bcd", bcd, 20'h00007);
        @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        chk_hex("c7", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78);
`else
        chk_hex("c7", 7'h40, 7'h40, 7'h40, 7'h40, 7'h78);
`endif
        pulse(14'd0);
        wait_idle(n);
        chk("c0_bcd", bcd, 20'h00000);
        @(negedge clock);
`ifdef LEADING_ZERO_BLANK_EN
        chk_hex("c0", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
        chk_hex("c0", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
